tdm_demux8: RTL and testbench

TDM_DEMUX8 -- requirements
Module: tdm_demux8

---
 rtl/tdm_demux_pkg.sv | 5 +
 rtl/tdm_slot_ctr.sv | 19 +
 rtl/tdm_demux8.sv | 72 +++++++
 tb/tb_tdm_demux8.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared FSM state type and default frame size for the TDM demux
package tdm_demux_pkg;
    typedef enum logic {HUNT, LOCKED} state_t;
    localparam int TDM_N_CH_DEFAULT = 8;
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: slot index counter with clear, load-1 and wrapping increment
module tdm_slot_ctr #(
    parameter int N_CH  = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load1,
    input  logic             inc,
    output logic [SEL_W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (load1) cnt <= SEL_W'(1);
        else if (inc) cnt <= (cnt == SEL_W'(N_CH - 1)) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/tdm_demux8.sv
// tdm_demux8: serial TDM frame demux with sync lock; TDM_DEMUX_ERRCNT_EN adds err_count
module tdm_demux8 import tdm_demux_pkg::*; #(
    parameter int N_CH  = TDM_N_CH_DEFAULT,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [N_CH-1:0]  out,
    output logic             out_valid,
    output logic [SEL_W-1:0] sel,
    output logic             locked,
    output logic             frame_err
`ifdef TDM_DEMUX_ERRCNT_EN
    ,output logic [7:0]      err_count
`endif
);
    state_t state, state_nxt;
    logic [N_CH-1:0] shadow, shadow_nxt;
    logic [SEL_W-1:0] slot;
    logic at_zero, at_last, drop, take, sync_err, done;

    // A sync beat always lands in slot 0, whichever state it interrupts
    always_comb begin
        at_zero    = sel == '0;
        at_last    = sel == SEL_W'(N_CH - 1);
        drop       = din_valid && state == LOCKED && at_zero && !frame_sync;
        take       = din_valid && (frame_sync || state == LOCKED) && !drop;
        sync_err   = din_valid && state == LOCKED && (at_zero != frame_sync);
        done       = take && !frame_sync && at_last;
        slot       = frame_sync ? '0 : sel;
        shadow_nxt = shadow;
        shadow_nxt[slot] = din;
        state_nxt  = take ? LOCKED : drop ? HUNT : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            shadow    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            shadow    <= take ? shadow_nxt : shadow;
            out       <= done ? shadow_nxt : out;
            out_valid <= done;
            frame_err <= sync_err;
        end
    end

    tdm_slot_ctr #(.N_CH(N_CH), .SEL_W(SEL_W)) u_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (drop),
        .load1 (take && frame_sync),
        .inc   (take && !frame_sync),
        .cnt   (sel)
    );

    assign locked = state == LOCKED;

`ifdef TDM_DEMUX_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_count <= '0;
        else if (frame_err && err_count != 8'hff) err_count <= err_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: directed stimulus with an out_valid/frame_err scoreboard monitor
module tb_tdm_demux8;
    logic       clk = 1'b0;
    logic       rst, din, din_valid, frame_sync;
    logic [7:0] out;
    logic       out_valid, locked, frame_err;
    logic [2:0] sel;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int tests = 0;
    int fails = 0;
    int err_exp = 0;
    int err_seen = 0;
    logic [7:0] exp_q[$];

    tdm_demux8 #(.N_CH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .out        (out),
        .out_valid  (out_valid),
        .sel        (sel),
        .locked     (locked),
        .frame_err  (frame_err)
`ifdef TDM_DEMUX_ERRCNT_EN
        ,.err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest expected frame
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out_valid: got out=%0h expected no pulse", out);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (out !== e) begin
                        fails++;
                        $display("FAIL frame_out: got %0h expected %0h", out, e);
                    end
                end
            end
            if (frame_err) err_seen++;
            if (frame_err && out_valid) begin
                tests++;
                fails++;
                $display("FAIL err_and_valid: got both high expected exclusive");
            end
        end
    end

    task automatic beat(input logic d, input logic fs);
        din = d;
        frame_sync = fs;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] v);
        beat(v[0], 1'b1);
        for (int i = 1; i < 8; i++) begin
            if (i == 7) exp_q.push_back(v);
            beat(v[i], 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b0;
        din_valid = 1'b0;
        frame_sync = 1'b0;
        #3;
        check("reset_out", out, 8'h00);
        check("reset_sel", sel, 3'd0);
        check("reset_locked", locked, 1'b0);
        check("reset_flags", {out_valid, frame_err}, 2'b00);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Unsynced beats in HUNT are ignored
        beat(1'b1, 1'b0);
        check("hunt_sel", sel, 3'd0);
        check("hunt_locked", locked, 1'b0);

        // First frame 0x22
        beat(1'b0, 1'b1);
        check("sync_sel", sel, 3'd1);
        check("sync_locked", locked, 1'b1);
        for (int i = 1; i < 8; i++) begin
            logic [7:0] v;
            v = 8'h22;
            if (i == 7) exp_q.push_back(v);
            beat(v[i], 1'b0);
        end
        check("f1_out", out, 8'h22);
        check("f1_valid", out_valid, 1'b1);
        check("f1_locked", locked, 1'b1);
        check("f1_sel_wrap", sel, 3'd0);
        idle(1);
        check("f1_valid_once", out_valid, 1'b0);

        // Frame 0x80 with a 3-cycle gap between beats 4 and 5
        begin
            logic [7:0] v;
            v = 8'h80;
            beat(v[0], 1'b1);
            for (int i = 1; i < 4; i++) beat(v[i], 1'b0);
            for (int g = 0; g < 3; g++) begin
                idle(1);
                check("gap_sel", sel, 3'd4);
                check("gap_out_hold", out, 8'h22);
            end
            for (int i = 4; i < 8; i++) begin
                if (i == 7) exp_q.push_back(v);
                beat(v[i], 1'b0);
            end
        end
        check("f2_out", out, 8'h80);

        // Sync at sel=5 restarts the frame
        beat(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) beat(1'b1, 1'b0);
        check("pre_resync_sel", sel, 3'd5);
        err_exp++;
        beat(1'b0, 1'b1);
        check("resync_err", frame_err, 1'b1);
        check("resync_sel", sel, 3'd1);
        check("resync_locked", locked, 1'b1);
        check("resync_out_hold", out, 8'h80);
        begin
            logic [7:0] v;
            v = 8'h5a;
            for (int i = 1; i < 8; i++) begin
                if (i == 7) exp_q.push_back(v);
                beat(v[i], 1'b0);
            end
        end
        check("f3_out", out, 8'h5a);

        // Missing sync at sel=0 drops lock
        err_exp++;
        beat(1'b1, 1'b0);
        check("nosync_err", frame_err, 1'b1);
        check("nosync_locked", locked, 1'b0);
        check("nosync_sel", sel, 3'd0);
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0);
        check("hunt_ignore_sel", sel, 3'd0);
        check("hunt_ignore_out", out, 8'h5a);
        send_frame(8'hc3);
        check("f4_out", out, 8'hc3);

        // Back-to-back frames
        send_frame(8'h01);
        send_frame(8'hfe);
        check("b2b_out", out, 8'hfe);

        // Asynchronous reset mid-frame at sel=3
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        check("pre_rst_sel", sel, 3'd3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out", out, 8'h00);
        check("arst_sel", sel, 3'd0);
        check("arst_locked", locked, 1'b0);
        check("arst_flags", {out_valid, frame_err}, 2'b00);
        #3;
        rst = 1'b0;
        #4;
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0);
        check("post_rst_sel", sel, 3'd0);
        send_frame(8'h96);
        check("post_rst_out", out, 8'h96);

`ifdef TDM_DEMUX_ERRCNT_EN
        beat(1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            err_exp++;
            beat(1'b0, 1'b1);
        end
        idle(1);
        check("err_count_sat", err_count, 8'd255);
`endif

        idle(3);
        check("queue_drained", exp_q.size(), 0);
        check("frame_err_count", err_seen, err_exp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
